// File: rtl/instr_encoder.sv
// Program loader: packs {op_code, reg_s, acc_s, val} into 16-bit words and
// writes them sequentially into program memory from a start-armed base address.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        op_code,
    input  logic              reg_s,
    input  logic              acc_s,
    input  logic [7:0]        val,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              overflow
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [15:0] pack_word(input logic [5:0] op,
                                              input logic       rs,
                                              input logic       as,
                                              input logic [7:0] v);
        return {op, rs, as, v};
    endfunction

    state_t            state_q;
    logic [ADDR_W-1:0] wr_ptr_q;
    logic [ADDR_W:0]   count_q;
    logic              overflow_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [15:0]       mem_wdata_q;

    logic accept_s;
    logic at_top_s;

    assign accept_s = in_valid && (state_q == S_LOAD);
    assign at_top_s = (wr_ptr_q == {ADDR_W{1'b1}});

    // Load FSM with registered write port, pointer and status.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= {ADDR_W{1'b0}};
            count_q     <= {(ADDR_W+1){1'b0}};
            overflow_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 16'h0000;
        end else begin
            mem_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_LOAD;
                        wr_ptr_q   <= base_addr;
                        count_q    <= {(ADDR_W+1){1'b0}};
                        overflow_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (accept_s) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wr_ptr_q;
                        mem_wdata_q <= pack_word(op_code, reg_s, acc_s, val);
                        count_q     <= count_q + {{ADDR_W{1'b0}}, 1'b1};
                        // Pointer is held at the top so it never wraps within a load.
                        if (!at_top_s) begin
                            wr_ptr_q <= wr_ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        end
                        if (last || at_top_s) begin
                            state_q <= S_DONE;
                        end
                        if (at_top_s && !last) begin
                            overflow_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule
